// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a one-beat registered output slot.
// Optional macro ARB_LOCK_EN adds a_lock/b_lock so the last grantee can keep ownership.
module mux2_arbiter #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [n-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [n-1:0] b_data,
    output logic         b_ready,
`ifdef ARB_LOCK_EN
    input  logic         a_lock,
    input  logic         b_lock,
`endif
    output logic         out_valid,
    output logic [n-1:0] out_data,
    input  logic         out_ready,
    output logic         select,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [n-1:0] r_data;
    logic         r_select;
    logic         r_last;      // 1 = A granted most recently, 0 = B
    logic         w_out_valid;
    logic         w_free;
    logic         w_lock;
    logic         w_both_pick_a;
    logic         w_pick_a;
    logic         w_pick_b;
    logic         w_grant_a;
    logic         w_grant_b;
    logic         w_drain;

    assign w_out_valid = (r_state != IDLE);
    assign w_free      = !w_out_valid || out_ready;
    assign w_drain     = w_out_valid && out_ready;

`ifdef ARB_LOCK_EN
    // The last grantee keeps the slot under contention while it holds its lock.
    assign w_lock = r_last ? a_lock : b_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Under contention: locked last grantee wins, otherwise the other requester.
    assign w_both_pick_a = w_lock ? r_last : !r_last;
    assign w_pick_a      = a_valid && (!b_valid || w_both_pick_a);
    assign w_pick_b      = b_valid && !w_pick_a;

    // Reset masks the grant so no handshake can be seen while rst is high.
    assign w_grant_a = !rst && w_free && w_pick_a;
    assign w_grant_b = !rst && w_free && w_pick_b;

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign out_valid = w_out_valid;
    assign out_data  = r_data;
    assign select    = r_select;
    assign busy      = w_out_valid || a_valid || b_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a grant refills the slot, a bare drain empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant_a) begin
            w_state_nxt = HOLD_A;
        end else if (w_grant_b) begin
            w_state_nxt = HOLD_B;
        end else if (w_drain) begin
            w_state_nxt = IDLE;
        end
    end

    // Capture granted payload and source; they persist after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_select <= 1'b0;
        end else if (w_grant_a) begin
            r_data   <= a_data;
            r_select <= 1'b1;
        end else if (w_grant_b) begin
            r_data   <= b_data;
            r_select <= 1'b0;
        end
    end

    // Round-robin pointer moves only on a grant; resets to B so A wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_grant_a) begin
            r_last <= 1'b1;
        end else if (w_grant_b) begin
            r_last <= 1'b0;
        end
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: n, default 16, width of each data path.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  requester A holds a beat.
REQ-005 a_data  input  n  requester A payload.
REQ-006 a_ready  output  1  requester A's beat accepted this cycle.
REQ-007 b_valid, b_data, b_ready  as REQ-004..006, for requester B.
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  n  held beat, registered.
REQ-010 out_ready  input  1  consumer accepts the held beat this cycle.
REQ-011 select  output  1  registered source of the held beat: 1 = A, 0 = B; drives a 2:1 mux where 1 selects the first input.
REQ-012 busy  output  1  high when out_valid or either requester valid.

Function
REQ-013 A transfer occurs on an edge where x_valid && x_ready, or out_valid && out_ready.
REQ-014 Slot free = !out_valid || out_ready, so a drain and a new accept can occur on the same edge.
REQ-015 FSM states: IDLE (nothing held), HOLD_A (beat from A held), HOLD_B (beat from B held).
REQ-016 When the slot is free and only A is valid, grant A; when only B is valid, grant B.
REQ-017 When the slot is free and both are valid, grant the requester not in last; last is the most recently granted requester.
REQ-018 Grant is combinational: a_ready = slot free && grant A, and b_ready likewise; both are never high together.
REQ-019 When the slot is not free, a_ready = b_ready = 0.
REQ-020 On a grant edge: out_data <= granted data; select <= 1 for A, 0 for B; out_valid <= 1; state -> HOLD_A or HOLD_B; last <= grantee.
REQ-021 On a drain with no grant on the same edge: out_valid <= 0 and state -> IDLE. out_data and select keep their last values.
REQ-022 While out_valid && !out_ready, out_data, select and state remain stable.
REQ-023 Latency from accept edge to out_valid high is 1 cycle. Throughput is 1 beat per cycle when out_ready is held high.
REQ-024 The input valid signals are not required to stay high. A requester that drops valid before being granted is not served.
REQ-025 last toggles only on a grant. There are no idle-cycle pointer updates.

Reset
REQ-026 While rst is high, independent of clk: out_valid=0, out_data=0, select=0, state=IDLE, last=B (so A wins the first contention), a_ready=b_ready=0.
REQ-027 Reset mid-operation discards any held beat and does not signal its loss.
REQ-028 After rst falls, the first rising edge may grant.

Configuration
REQ-029 Macro ARB_LOCK_EN.
REQ-030 ARB_LOCK_EN defined: adds input ports a_lock and b_lock, each 1 bit. If the requester named in last has its lock and valid both high while the other requester is also valid, that requester wins arbitration. last is unchanged while this lock win applies.
REQ-031 ARB_LOCK_EN undefined: the lock ports are absent and arbitration is pure round-robin per REQ-016..017.

Verification
REQ-032 Reset: rst=1 mid-hold with out_valid=1 -> out_valid=0, select=0, out_data=0 immediately, before the next clk edge.
REQ-033 Single requester: a_valid=1, a_data=16'h1234, out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=16'h1234, select=1.
REQ-034 Contention: both valid for 4 cycles, a_data=16'hAAAA, b_data=16'hBBBB, out_ready=1 -> out_data sequence AAAA, BBBB, AAAA, BBBB; select 1,0,1,0.
REQ-035 Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data stable; a_ready=b_ready=0. Raise out_ready -> the held beat drains and the next grant is captured on the same edge.
REQ-036 Drain to idle: single beat from B, then no valid and out_ready=1 -> out_valid falls after 1 cycle and busy=0.
REQ-037 ARB_LOCK_EN: a_lock=1, both valid for 3 cycles -> A granted all 3 cycles. Drop a_lock -> B granted next.
